data_responder: RTL and testbench

Word-addressed data-memory responder that answers the single-cycle RV32I core's data port (MemWrite, ALUResult as address, WriteData, ReadData). It holds the data RAM, a 64-bit cycle counter with snapshot registers, and a byte-wide console transmit FIFO. The FIFO drains through a ready/valid port to an off-core console sink. Reads are combinational, so a load completes in the core's single cycle; all state changes occur on the rising clock edge.

---
 rtl/data_responder.sv | 118 +++++++++++
 tb/tb_data_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_responder.sv
// rtl/data_responder.sv - data RAM, cycle-counter snapshot and console TX FIFO on the core data port
// Purpose: answers the single-cycle core's data port with combinational reads and edge-timed writes.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   MemWrite, DataAdr,       store strobe, byte address (bits [1:0] ignored), store data
//   WriteData
//   ReadData                 combinational read data for DataAdr
//   ConsoleData/Valid/Ready  FIFO head byte, non-empty flag, sink accept
module data_responder #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  ConsoleData,
   output logic        ConsoleValid,
   input  logic        ConsoleReady
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   DEPTH = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PONE  = PW'(1);

   localparam logic [29:0] TX_W      = 30'h2000_0000;
   localparam logic [29:0] STATUS_W  = 30'h2000_0001;
   localparam logic [29:0] SNAP_LO_W = 30'h2000_0002;
   localparam logic [29:0] SNAP_HI_W = 30'h2000_0003;

   logic [31:0]   mem [RAM_WORDS];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          ovf, err;
   logic [63:0]   cycle_cnt, snapshot;

   logic [29:0] word;
   logic        is_ram, is_tx, is_status, is_snap_lo, is_snap_hi, mapped;
   logic        full, empty, pop, push_req, push_ok, push_drop;
   logic        unused_lsb;

   assign word       = DataAdr[31:2];
   assign unused_lsb = ^DataAdr[1:0];
   assign is_ram     = (DataAdr[31:AW+2] == '0);
   assign is_tx      = (word == TX_W);
   assign is_status  = (word == STATUS_W);
   assign is_snap_lo = (word == SNAP_LO_W);
   assign is_snap_hi = (word == SNAP_HI_W);
   assign mapped     = is_ram | is_tx | is_status | is_snap_lo | is_snap_hi;

   assign empty        = (count == '0);
   assign full         = (count == DEPTH);
   assign ConsoleValid = !empty;
   // Head is forced to 0 while empty so the output is defined even though storage is never reset.
   assign ConsoleData  = ConsoleValid ? fifo[rd_ptr] : 8'h00;

   assign pop       = ConsoleValid && ConsoleReady;
   assign push_req  = MemWrite && is_tx;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign push_ok   = push_req && (!full || pop);
   assign push_drop = push_req && !push_ok;

   always_comb begin
      ReadData = 32'h0;
      if (is_ram)
         ReadData = mem[DataAdr[AW+1:2]];
      else if (is_status)
         ReadData = {28'h0, err, ovf, full, empty};
      else if (is_snap_lo)
         ReadData = snapshot[31:0];
      else if (is_snap_hi)
         ReadData = snapshot[63:32];
   end

   always_ff @(posedge clk) begin
      if (MemWrite && is_ram)
         mem[DataAdr[AW+1:2]] <= WriteData;
      if (push_ok)
         fifo[wr_ptr] <= WriteData[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         cycle_cnt <= 64'h0;
         snapshot  <= 64'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (MemWrite && is_snap_lo)
            snapshot <= cycle_cnt;
         if (push_ok)
            wr_ptr <= wr_ptr + PONE;
         if (pop)
            rd_ptr <= rd_ptr + PONE;
         if (push_ok && !pop)
            count <= count + CONE;
         else if (!push_ok && pop)
            count <= count - CONE;
         if (MemWrite && is_status) begin
            ovf <= 1'b0;
            err <= 1'b0;
         end
         // Ordered after the clear so a drop in the same cycle leaves ovf set.
         if (push_drop)
            ovf <= 1'b1;
         if (MemWrite && !mapped)
            err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_data_responder.sv
// tb/tb_data_responder.sv - scoreboard bench for data_responder
module tb_data_responder;
   localparam int DEPTH = 4;
   localparam logic [31:0] TX      = 32'h8000_0000;
   localparam logic [31:0] STATUS  = 32'h8000_0004;
   localparam logic [31:0] SNAP_LO = 32'h8000_0008;
   localparam logic [31:0] SNAP_HI = 32'h8000_000C;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  ConsoleData;
   logic        ConsoleValid;
   logic        ConsoleReady;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   always #10 clk = ~clk;

   data_responder #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .MemWrite     (MemWrite),
      .DataAdr      (DataAdr),
      .WriteData    (WriteData),
      .ReadData     (ReadData),
      .ConsoleData  (ConsoleData),
      .ConsoleValid (ConsoleValid),
      .ConsoleReady (ConsoleReady)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives one store for one clock edge; the scoreboard learns of accepted TX bytes here.
   task automatic bus_write(input logic [31:0] adr, input logic [31:0] data, input logic rdy);
      @(negedge clk);
      ConsoleReady = rdy;
      MemWrite     = 1'b1;
      DataAdr      = adr;
      WriteData    = data;
      if (adr == TX && (exp_q.size() < DEPTH || (rdy && exp_q.size() != 0)))
         exp_q.push_back(data[7:0]);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      MemWrite = 1'b0;
      DataAdr  = adr;
      #1;
      check_eq(tag, ReadData, exp);
   endtask

   task automatic drain(input string tag, input int exp_cycles);
      int n = 0;
      @(negedge clk);
      ConsoleReady = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq(tag, n, exp_cycles);
   endtask

   // Console monitor: just before each rising edge, a pop about to happen must carry the oldest expected byte.
   initial begin
      forever begin
         @(negedge clk);
         #8;
         if (!reset && ConsoleValid && ConsoleReady) begin
            logic [8:0] exp;
            exp = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check_eq("con_byte", {55'h0, 1'b0, ConsoleData}, {55'h0, exp});
         end
      end
   end

   initial begin
      reset        = 1'b1;
      MemWrite     = 1'b0;
      DataAdr      = 32'h0;
      WriteData    = 32'h0;
      ConsoleReady = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check_eq("rst_valid", ConsoleValid, 0);
      check_eq("rst_data", ConsoleData, 0);
      bus_read("rst_status", STATUS, 32'h1);
      bus_read("rst_snap_lo", SNAP_LO, 32'h0);
      bus_read("rst_snap_hi", SNAP_HI, 32'h0);

      // Snapshot at the 10th edge after reset release
      repeat (9) @(posedge clk);
      bus_write(SNAP_LO, 32'hFFFF_FFFF, 1'b0);
      bus_read("snap_lo_9", SNAP_LO, 32'd9);
      bus_read("snap_hi_9", SNAP_HI, 32'h0);
      bus_write(SNAP_HI, 32'h1234_5678, 1'b0);
      bus_read("snap_hi_wr_ign", SNAP_HI, 32'h0);

      // RAM store/load, low address bits ignored
      bus_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      bus_read("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
      bus_read("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
      bus_write(32'h0000_00FC, 32'hA5A5_0001, 1'b0);
      bus_read("ram_top", 32'h0000_00FC, 32'hA5A5_0001);
      bus_read("ram_10_keep", 32'h0000_0010, 32'hDEAD_BEEF);

      // Overflow with the sink stalled
      for (int i = 0; i < 5; i++)
         bus_write(TX, 32'h41 + i, 1'b0);
      bus_read("ovf_status", STATUS, 32'h6);
      bus_read("tx_read0", TX, 32'h0);
      check_eq("stall_valid", ConsoleValid, 1);
      check_eq("stall_head", ConsoleData, 8'h41);
      drain("drain_4", 4);
      bus_read("drained_status", STATUS, 32'h5);
      bus_write(STATUS, 32'h0, 1'b1);
      bus_read("clr_status", STATUS, 32'h1);

      // Push into a full FIFO in the same cycle as a pop
      for (int i = 0; i < 4; i++)
         bus_write(TX, 32'h61 + i, 1'b0);
      bus_read("full_status", STATUS, 32'h2);
      bus_write(TX, 32'h55, 1'b1);
      bus_read("push_pop_status", STATUS, 32'h2);
      drain("drain_pp", 4);
      bus_read("pp_empty_status", STATUS, 32'h1);

      // Unmapped write sets err and leaves RAM alone
      bus_write(32'h4000_0000, 32'h1234_5678, 1'b0);
      bus_read("err_status", STATUS, 32'h9);
      bus_read("err_rd0", 32'h4000_0000, 32'h0);
      bus_read("err_ram_keep", 32'h0000_0000 + 32'h10, 32'hDEAD_BEEF);
      bus_write(STATUS, 32'h0, 1'b0);
      bus_read("err_clr", STATUS, 32'h1);

      // Counter wrap
      @(negedge clk);
      force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      bus_write(SNAP_LO, 32'h0, 1'b0);
      bus_read("wrap_lo", SNAP_LO, 32'h0);
      bus_read("wrap_hi", SNAP_HI, 32'h0);

      // Reset with three bytes queued and ovf set
      for (int i = 0; i < 5; i++)
         bus_write(TX, 32'h71 + i, 1'b0);
      @(negedge clk);
      ConsoleReady = 1'b1;
      @(negedge clk);
      ConsoleReady = 1'b0;
      bus_read("pre_rst_status", STATUS, 32'h4);
      bus_write(SNAP_LO, 32'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      check_eq("mid_rst_valid", ConsoleValid, 0);
      bus_read("mid_rst_status", STATUS, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("post_rst_data", ConsoleData, 0);
      bus_read("post_rst_snap", SNAP_LO, 32'h0);
      bus_read("post_rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
